// File: rtl/avg_pkg.sv
// Shared types and helpers for the multi-channel moving-average engine.
package avg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Running-sum width: a full window of max-valued samples fits exactly.
    function automatic int sum_width(input int data_w, input int win_log2);
        return data_w + win_log2;
    endfunction

endpackage

// File: rtl/avg_sample_ram.sv
// Single-port sample window RAM, addressed {channel, slot}, registered read data.
module avg_sample_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_r;

    // Memory array write port; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wr_data;
        end
    end

    // Synchronous read register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else begin
            rd_data_r <= mem_r[addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/moving_avg_multi.sv
// Multi-channel sliding-window moving average; one update per accepted sample,
// using a per-channel running sum and a shared sample RAM.
module moving_avg_multi
    import avg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WIN_LOG2 = 5,
    parameter int CHANNELS = 4,
    parameter int CH_W     = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] stock_price,
    input  logic [CH_W-1:0]   channel,
    input  logic              data_ready,
    input  logic              clear,
    output logic              ready,
    output logic [DATA_W-1:0] average,
    output logic [CH_W-1:0]   avg_channel,
    output logic              avg_valid,
    output logic              avg_full,
    output logic              overrun
);

    localparam int SUM_W  = sum_width(DATA_W, WIN_LOG2);
    localparam int CNT_W  = WIN_LOG2 + 1;
    localparam int ADDR_W = CH_W + WIN_LOG2;
    localparam int DEPTH  = CHANNELS * (2 ** WIN_LOG2);
    localparam logic [CNT_W-1:0] WIN_CNT  = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W-1:0]   sample_r;
    logic [CH_W-1:0]     ch_r;
    logic [SUM_W-1:0]    sum_r [0:CHANNELS-1];
    logic [WIN_LOG2-1:0] ptr_r [0:CHANNELS-1];
    logic [CNT_W-1:0]    cnt_r [0:CHANNELS-1];
    logic                ready_r;
    logic [DATA_W-1:0]   average_r;
    logic [CH_W-1:0]     avg_channel_r;
    logic                avg_valid_r;
    logic                avg_full_r;
    logic                overrun_r;

    logic                accept_s;
    logic                full_s;
    logic [SUM_W-1:0]    new_sum_s;
    logic [CNT_W-1:0]    new_cnt_s;
    logic [DATA_W-1:0]   old_sample_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic                ram_we_s;

    assign accept_s   = (state_r == IDLE) && data_ready && !clear &&
                        ({1'b0, channel} < CH_LIMIT);
    assign ram_addr_s = {ch_r, ptr_r[ch_r]};
    assign ram_we_s   = (state_r == UPDATE) && !clear;

    avg_sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .n_rst   (n_rst),
        .addr    (ram_addr_s),
        .we      (ram_we_s),
        .wr_data (sample_r),
        .rd_data (old_sample_s)
    );

    // Next-state decode; clear forces IDLE from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = accept_s ? FETCH : IDLE;
                FETCH:   state_nxt_s = UPDATE;
                UPDATE:  state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Sum/count update for the channel being processed; the evicted sample is
    // only subtracted once the window is full, so no underflow is possible.
    always_comb begin
        full_s    = (cnt_r[ch_r] == WIN_CNT);
        new_sum_s = sum_r[ch_r] + {{WIN_LOG2{1'b0}}, sample_r};
        if (full_s) begin
            new_sum_s = new_sum_s - {{WIN_LOG2{1'b0}}, old_sample_s};
            new_cnt_s = cnt_r[ch_r];
        end else begin
            new_cnt_s = cnt_r[ch_r] + CNT_W'(1'b1);
        end
    end

    // FSM state, ready flag and latched sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r  <= IDLE;
            ready_r  <= 1'b1;
            sample_r <= {DATA_W{1'b0}};
            ch_r     <= {CH_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            if (accept_s) begin
                sample_r <= stock_price;
                ch_r     <= channel;
            end
        end
    end

    // Per-channel running sums, write pointers and fill counts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sum_r[i] <= {SUM_W{1'b0}};
                ptr_r[i] <= {WIN_LOG2{1'b0}};
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else if (clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sum_r[i] <= {SUM_W{1'b0}};
                ptr_r[i] <= {WIN_LOG2{1'b0}};
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else if (state_r == UPDATE) begin
            sum_r[ch_r] <= new_sum_s;
            ptr_r[ch_r] <= ptr_r[ch_r] + WIN_LOG2'(1'b1);
            cnt_r[ch_r] <= new_cnt_s;
        end
    end

    // Output registers; average fields survive clear, the valid pulse does not.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            average_r     <= {DATA_W{1'b0}};
            avg_channel_r <= {CH_W{1'b0}};
            avg_valid_r   <= 1'b0;
            avg_full_r    <= 1'b0;
        end else if (!clear && (state_r == UPDATE)) begin
            average_r     <= new_sum_s[SUM_W-1:WIN_LOG2];
            avg_channel_r <= ch_r;
            avg_valid_r   <= 1'b1;
            avg_full_r    <= (new_cnt_s == WIN_CNT);
        end else begin
            avg_valid_r   <= 1'b0;
        end
    end

    // Sticky overrun: strobe arrived while busy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun_r <= 1'b0;
        end else if (clear) begin
            overrun_r <= 1'b0;
        end else if (data_ready && !ready_r) begin
            overrun_r <= 1'b1;
        end
    end

    assign ready       = ready_r;
    assign average     = average_r;
    assign avg_channel = avg_channel_r;
    assign avg_valid   = avg_valid_r;
    assign avg_full    = avg_full_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_moving_avg_multi.sv
// Directed self-checking bench for moving_avg_multi (WIN_LOG2=2, CHANNELS=4).
module tb_moving_avg_multi;

    localparam int DATA_W   = 32;
    localparam int WIN_LOG2 = 2;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;

    logic              clk;
    logic              n_rst;
    logic [DATA_W-1:0] stock_price;
    logic [CH_W-1:0]   channel;
    logic              data_ready;
    logic              clear;
    logic              ready;
    logic [DATA_W-1:0] average;
    logic [CH_W-1:0]   avg_channel;
    logic              avg_valid;
    logic              avg_full;
    logic              overrun;

    int n_vec;
    int n_err;

    moving_avg_multi #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .stock_price (stock_price),
        .channel     (channel),
        .data_ready  (data_ready),
        .clear       (clear),
        .ready       (ready),
        .average     (average),
        .avg_channel (avg_channel),
        .avg_valid   (avg_valid),
        .avg_full    (avg_full),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe one sample at a negedge, then check latency and the resulting average.
    task automatic send(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] val,
                        input logic [DATA_W-1:0] exp_avg, input logic exp_full);
        @(negedge clk);
        check_eq("ready_before", ready, 64'd1);
        data_ready  = 1'b1;
        channel     = ch;
        stock_price = val;
        @(negedge clk);
        data_ready = 1'b0;
        check_eq("busy_fetch", ready, 64'd0);
        check_eq("valid_t1", avg_valid, 64'd0);
        @(negedge clk);
        check_eq("valid_t2", avg_valid, 64'd0);
        @(negedge clk);
        check_eq("valid_t3", avg_valid, 64'd1);
        check_eq("average", average, {32'd0, exp_avg});
        check_eq("avg_full", avg_full, {63'd0, exp_full});
        check_eq("avg_channel", avg_channel, {62'd0, ch});
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        n_rst       = 1'b0;
        clear       = 1'b0;
        data_ready  = 1'b0;
        channel     = 2'd0;
        stock_price = 32'd0;

        // 1 reset
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", ready, 64'd1);
        check_eq("rst_valid", avg_valid, 64'd0);
        check_eq("rst_average", average, 64'd0);
        check_eq("rst_overrun", overrun, 64'd0);

        // 2 fill ch0
        send(2'd0, 32'd4,  32'd1,  1'b0);
        send(2'd0, 32'd8,  32'd3,  1'b0);
        send(2'd0, 32'd12, 32'd6,  1'b0);
        send(2'd0, 32'd16, 32'd10, 1'b1);
        @(negedge clk);
        check_eq("valid_one_cycle", avg_valid, 64'd0);

        // 3 eviction and pointer wrap
        send(2'd0, 32'd20, 32'd14, 1'b1);
        send(2'd0, 32'd0,  32'd12, 1'b1);

        // 4 interleaved channels; ch0 window {20,0,12,16}, 12 evicted next
        send(2'd1, 32'd100, 32'd25,  1'b0);
        send(2'd2, 32'd200, 32'd50,  1'b0);
        send(2'd1, 32'd300, 32'd100, 1'b0);
        send(2'd0, 32'd4,   32'd10,  1'b1);

        // 5 overrun: second strobe one cycle after an accepted one
        @(negedge clk);
        data_ready  = 1'b1;
        channel     = 2'd1;
        stock_price = 32'd4;
        @(negedge clk);
        channel     = 2'd2;
        stock_price = 32'd999;
        @(negedge clk);
        data_ready = 1'b0;
        check_eq("overrun_set", overrun, 64'd1);
        @(negedge clk);
        check_eq("ovr_valid", avg_valid, 64'd1);
        check_eq("ovr_average", average, 64'd101);
        check_eq("ovr_channel", avg_channel, 64'd1);
        check_eq("ovr_full", avg_full, 64'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_eq("overrun_clr", overrun, 64'd0);
        check_eq("clr_ready", ready, 64'd1);

        // 6 clear during FETCH aborts the update
        @(negedge clk);
        data_ready  = 1'b1;
        channel     = 2'd0;
        stock_price = 32'd77;
        @(negedge clk);
        data_ready = 1'b0;
        clear      = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_eq("abort_valid0", avg_valid, 64'd0);
        check_eq("abort_ready", ready, 64'd1);
        @(negedge clk);
        check_eq("abort_valid1", avg_valid, 64'd0);
        @(negedge clk);
        check_eq("abort_valid2", avg_valid, 64'd0);
        check_eq("avg_held", average, 64'd101);
        send(2'd0, 32'd40, 32'd10, 1'b0);

        // 7 all-ones saturation of the window sum
        send(2'd3, 32'hFFFF_FFFF, 32'h3FFF_FFFF, 1'b0);
        send(2'd3, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        send(2'd3, 32'hFFFF_FFFF, 32'hBFFF_FFFF, 1'b0);
        send(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
